// File: rtl/spi_slave_with_cs.sv
// spi_slave_with_cs
//   SPI responder with a single active-low chip select. SCK, CS_n and MOSI are
//   oversampled in the i_Clk domain. MOSI is deserialized MSB first into bytes.
//   A one-entry TX holding register feeds a shifter that drives MISO, and a
//   saturating per-frame byte index is reported with each received byte.
//   All four SPI modes are supported through SPI_MODE (CPOL = bit 1, CPHA = bit 0).
//
// Ports
//   i_Rst_L        async active-low reset
//   i_Clk          system clock (rising edge)
//   i_SPI_Clk      SCK from master (async)
//   i_SPI_CS_n     chip select, active low (async)
//   i_SPI_MOSI     serial data in (async)
//   o_SPI_MISO     serial data out
//   o_SPI_MISO_En  MISO drive enable while a frame is open
//   i_TX_Byte      byte to transmit, written on i_TX_DV when o_TX_Ready
//   i_TX_DV        TX load strobe
//   o_TX_Ready     TX holding register empty
//   o_TX_Underrun  pulse: a byte slot started with nothing to send
//   o_RX_Byte      last complete received byte
//   o_RX_DV        pulse: o_RX_Byte / o_RX_Count valid
//   o_RX_Count     1-based byte index in frame, saturating at MAX_BYTES_PER_CS
module spi_slave_with_cs #(
  parameter int SPI_MODE         = 3,
  parameter int MAX_BYTES_PER_CS = 2,
  localparam int CW              = $clog2(MAX_BYTES_PER_CS + 1)
) (
  input  logic          i_Rst_L,
  input  logic          i_Clk,
  input  logic          i_SPI_Clk,
  input  logic          i_SPI_CS_n,
  input  logic          i_SPI_MOSI,
  output logic          o_SPI_MISO,
  output logic          o_SPI_MISO_En,
  input  logic [7:0]    i_TX_Byte,
  input  logic          i_TX_DV,
  output logic          o_TX_Ready,
  output logic          o_TX_Underrun,
  output logic [7:0]    o_RX_Byte,
  output logic          o_RX_DV,
  output logic [CW-1:0] o_RX_Count
);

  localparam bit CPOL = ((SPI_MODE >> 1) & 1) != 0;
  localparam bit CPHA = (SPI_MODE & 1) != 0;

  typedef enum logic [1:0] {IDLE, LOAD, ACTIVE} state_e;
  state_e state_q, state_d;

  logic sck_s1_q, sck_s2_q, sck_prev_q;
  logic cs_s1_q, cs_s2_q, cs_prev_q;
  logic mosi_s1_q, mosi_s2_q;

  logic [7:0]    rx_sr_q, tx_sr_q, hold_q, rx_byte_q;
  logic [2:0]    bit_cnt_q;
  logic [CW-1:0] cnt_q;
  logic          done_q, skip_q, full_q, miso_q, rx_dv_q, undr_q;

  logic cs_fall, cs_rise, sck_rise, sck_fall, lead_edge, trail_edge;
  logic in_frame, sample_edge, shift_edge, do_load, accept;

  // Sync flops reset to the bus idle levels so no edge is seen out of reset.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sck_s1_q   <= CPOL;
      sck_s2_q   <= CPOL;
      sck_prev_q <= CPOL;
      cs_s1_q    <= 1'b1;
      cs_s2_q    <= 1'b1;
      cs_prev_q  <= 1'b1;
      mosi_s1_q  <= 1'b0;
      mosi_s2_q  <= 1'b0;
    end else begin
      sck_s1_q   <= i_SPI_Clk;
      sck_s2_q   <= sck_s1_q;
      sck_prev_q <= sck_s2_q;
      cs_s1_q    <= i_SPI_CS_n;
      cs_s2_q    <= cs_s1_q;
      cs_prev_q  <= cs_s2_q;
      mosi_s1_q  <= i_SPI_MOSI;
      mosi_s2_q  <= mosi_s1_q;
    end
  end

  assign cs_fall    = cs_prev_q & ~cs_s2_q;
  assign cs_rise    = ~cs_prev_q & cs_s2_q;
  assign sck_rise   = ~sck_prev_q & sck_s2_q;
  assign sck_fall   = sck_prev_q & ~sck_s2_q;
  assign lead_edge  = CPOL ? sck_fall : sck_rise;
  assign trail_edge = CPOL ? sck_rise : sck_fall;
  assign in_frame   = (state_q != IDLE) & ~cs_rise;
  assign sample_edge = in_frame & (CPHA ? trail_edge : lead_edge);
  assign shift_edge  = in_frame & (CPHA ? lead_edge : trail_edge);
  assign accept      = i_TX_DV & ~full_q;

  // do_load marks the edge that enters LOAD; the load happens on that edge.
  always_comb begin
    state_d = state_q;
    do_load = 1'b0;
    case (state_q)
      IDLE:    if (cs_fall) begin state_d = LOAD; do_load = 1'b1; end
      LOAD:    state_d = ACTIVE;
      ACTIVE:  if (done_q) begin state_d = LOAD; do_load = 1'b1; end
      default: state_d = IDLE;
    endcase
    if (cs_rise) begin
      state_d = IDLE;
      do_load = 1'b0;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      rx_sr_q   <= '0;
      tx_sr_q   <= '0;
      hold_q    <= '0;
      rx_byte_q <= '0;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      skip_q    <= 1'b0;
      full_q    <= 1'b0;
      miso_q    <= 1'b0;
      rx_dv_q   <= 1'b0;
      undr_q    <= 1'b0;
    end else begin
      rx_dv_q <= 1'b0;
      undr_q  <= 1'b0;
      done_q  <= 1'b0;
      if (cs_rise) begin
        // Partial byte is dropped; shifter contents are simply abandoned.
        bit_cnt_q <= '0;
        skip_q    <= 1'b0;
        cnt_q     <= '0;
      end else begin
        if (sample_edge) begin
          rx_sr_q <= {rx_sr_q[6:0], mosi_s2_q};
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_q <= '0;
            done_q    <= 1'b1;
            // CPHA=0: LOAD will present the next MSB, so the trailing edge
            // right after the last sample must not shift.
            skip_q    <= ~CPHA;
          end else begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
          end
        end
        if (shift_edge) begin
          if (skip_q) begin
            skip_q <= 1'b0;
          end else begin
            miso_q  <= CPHA ? tx_sr_q[7] : tx_sr_q[6];
            tx_sr_q <= {tx_sr_q[6:0], 1'b0};
          end
        end
        if (done_q) begin
          rx_dv_q   <= 1'b1;
          rx_byte_q <= rx_sr_q;
          cnt_q     <= (cnt_q == CW'(MAX_BYTES_PER_CS)) ? cnt_q : cnt_q + 1'b1;
        end
        if (do_load) begin
          tx_sr_q <= full_q ? hold_q : 8'h00;
          undr_q  <= ~full_q;
          if (!CPHA) miso_q <= full_q & hold_q[7];
        end
      end
      // LOAD reads the old holding value; a same-cycle write refills it.
      if (accept) hold_q <= i_TX_Byte;
      full_q <= accept | (full_q & ~do_load);
    end
  end

  assign o_SPI_MISO    = miso_q;
  assign o_SPI_MISO_En = (state_q != IDLE);
  assign o_TX_Ready    = ~full_q;
  assign o_TX_Underrun = undr_q;
  assign o_RX_Byte     = rx_byte_q;
  assign o_RX_DV       = rx_dv_q;
  assign o_RX_Count    = cnt_q;

endmodule

// File: tb/tb_spi_slave_with_cs.sv
// Bench for spi_slave_with_cs: one instance per SPI mode sharing SCK/MOSI,
// each with its own chip select, driven by a behavioural master.
module tb_spi_slave_with_cs;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            sck, mosi;
  logic [3:0]      cs_n, miso, miso_en, tx_dv, tx_rdy, undr, rx_dv;
  logic [3:0][7:0] tx_byte, rx_byte;
  logic [3:0][1:0] rx_cnt;

  int total = 0;
  int bad   = 0;
  int cur_m = 3;
  logic [15:0] rxq[$];
  int          und_tags[$];
  logic [7:0]  mtx[3];
  logic [7:0]  mrx[3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_with_cs #(.SPI_MODE(g), .MAX_BYTES_PER_CS(2)) u_dut (
      .i_Rst_L      (rst_n),
      .i_Clk        (clk),
      .i_SPI_Clk    (sck),
      .i_SPI_CS_n   (cs_n[g]),
      .i_SPI_MOSI   (mosi),
      .o_SPI_MISO   (miso[g]),
      .o_SPI_MISO_En(miso_en[g]),
      .i_TX_Byte    (tx_byte[g]),
      .i_TX_DV      (tx_dv[g]),
      .o_TX_Ready   (tx_rdy[g]),
      .o_TX_Underrun(undr[g]),
      .o_RX_Byte    (rx_byte[g]),
      .o_RX_DV      (rx_dv[g]),
      .o_RX_Count   (rx_cnt[g])
    );
  end

  // Log received bytes and underruns of the instance under test; each
  // underrun is tagged with how many bytes had been received by then.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_dv[cur_m]) rxq.push_back({rx_byte[cur_m], 6'd0, rx_cnt[cur_m]});
      if (undr[cur_m])  und_tags.push_back(rxq.size());
    end
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pop_rx();
    if (rxq.size() == 0) return 16'hDEAD;
    return rxq.pop_front();
  endfunction

  task automatic half();
    repeat (4) @(negedge clk);
  endtask

  task automatic load_tx(input int m, input logic [7:0] b);
    @(negedge clk);
    tx_byte[m] = b;
    tx_dv[m]   = 1'b1;
    @(negedge clk);
    tx_dv[m]   = 1'b0;
  endtask

  task automatic xfer(input int m, input logic [7:0] tx, input int nb, output logic [7:0] rx);
    logic cpol, cpha;
    cpol = ((m >> 1) & 1) != 0;
    cpha = (m & 1) != 0;
    rx = 8'h00;
    for (int i = 0; i < nb; i++) begin
      if (!cpha) begin
        mosi = tx[7-i];
        half();
        sck = ~cpol;
        rx = {rx[6:0], miso[m]};
        half();
        sck = cpol;
      end else begin
        sck = ~cpol;
        mosi = tx[7-i];
        half();
        sck = cpol;
        rx = {rx[6:0], miso[m]};
        half();
      end
    end
  endtask

  // nb bytes from mtx[]; the last one is cut to lastbits bits.
  task automatic frame(input int m, input int nb, input int lastbits);
    logic [7:0] r;
    sck = ((m >> 1) & 1) != 0;
    repeat (4) @(negedge clk);
    cs_n[m] = 1'b0;
    repeat (6) @(negedge clk);
    for (int b = 0; b < nb; b++) begin
      xfer(m, mtx[b], (b == nb - 1) ? lastbits : 8, r);
      mrx[b] = r;
    end
    repeat (8) @(negedge clk);
    cs_n[m] = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int n01;
    rst_n   = 1'b0;
    cs_n    = 4'hF;
    sck     = 1'b1;
    mosi    = 1'b0;
    tx_dv   = 4'h0;
    tx_byte = '0;
    repeat (3) @(negedge clk);
    chk("rst_miso",  {12'd0, miso},    16'h0000);
    chk("rst_en",    {12'd0, miso_en}, 16'h0000);
    chk("rst_ready", {12'd0, tx_rdy},  16'h000F);
    chk("rst_rx",    {rx_byte[3], 6'd0, rx_cnt[3]}, 16'h0000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Mode 3: preloaded A5, two bytes in one frame, second slot underruns.
    cur_m = 3;
    load_tx(3, 8'hA5);
    chk("t1_ready_low", {15'd0, tx_rdy[3]}, 16'h0000);
    mtx[0] = 8'hC1; mtx[1] = 8'hC2;
    frame(3, 2, 8);
    chk("t1_rx0", pop_rx(), 16'hC101);
    chk("t1_rx1", pop_rx(), 16'hC202);
    chk("t1_miso0", {8'd0, mrx[0]}, 16'h00A5);
    chk("t1_miso1", {8'd0, mrx[1]}, 16'h0000);
    n01 = 0;
    foreach (und_tags[i]) if (und_tags[i] <= 1) n01++;
    chk("t1_undr_load2", n01[15:0], 16'd1);
    chk("t1_undr_tag", (und_tags.size() > 0) ? und_tags[0][15:0] : 16'hFFFF, 16'd1);
    chk("t1_ready_back", {15'd0, tx_rdy[3]}, 16'h0001);

    // Modes 0..2: TX 3C, master sends 96.
    for (int m = 0; m < 3; m++) begin
      cur_m = m;
      rxq.delete();
      load_tx(m, 8'h3C);
      mtx[0] = 8'h96;
      frame(m, 1, 8);
      chk($sformatf("t2_rx_m%0d", m),   pop_rx(), 16'h9601);
      chk($sformatf("t2_miso_m%0d", m), {8'd0, mrx[0]}, 16'h003C);
      chk($sformatf("t2_en_m%0d", m),   {12'd0, miso_en}, 16'h0000);
    end

    // Count saturation at 2, restart on a new frame.
    cur_m = 3;
    rxq.delete();
    mtx[0] = 8'h11; mtx[1] = 8'h22; mtx[2] = 8'h33;
    frame(3, 3, 8);
    chk("t3_rx0", pop_rx(), 16'h1101);
    chk("t3_rx1", pop_rx(), 16'h2202);
    chk("t3_rx2", pop_rx(), 16'h3302);
    mtx[0] = 8'h44;
    frame(3, 1, 8);
    chk("t3_restart", pop_rx(), 16'h4401);

    // Aborted byte after 5 bits, then a clean byte.
    rxq.delete();
    mtx[0] = 8'hFF;
    frame(3, 1, 5);
    chk("t4_no_dv", rxq.size() > 0 ? 16'd1 : 16'd0, 16'd0);
    chk("t4_cnt",   {14'd0, rx_cnt[3]}, 16'h0000);
    chk("t4_byte_kept", {8'd0, rx_byte[3]}, 16'h0044);
    mtx[0] = 8'h5A;
    frame(3, 1, 8);
    chk("t4_rx", pop_rx(), 16'h5A01);

    // Write to a full holding register is dropped.
    load_tx(3, 8'h12);
    load_tx(3, 8'h77);
    chk("t5_ready", {15'd0, tx_rdy[3]}, 16'h0000);
    mtx[0] = 8'h00;
    frame(3, 1, 8);
    chk("t5_tx12", {8'd0, mrx[0]}, 16'h0012);
    frame(3, 1, 8);
    chk("t5_no77", {8'd0, mrx[0]}, 16'h0000);
    chk("t5_ready_back", {15'd0, tx_rdy[3]}, 16'h0001);

    // Reset in the middle of the second byte of a frame.
    mtx[0] = 8'hAB; mtx[1] = 8'hFF;
    fork
      frame(3, 2, 8);
      begin
        repeat (20) @(negedge clk);
        load_tx(3, 8'hFF);
        repeat (63) @(negedge clk);
        load_tx(3, 8'h55);
        repeat (13) @(negedge clk);
        chk("t6_pre_en",  {15'd0, miso_en[3]}, 16'h0001);
        chk("t6_pre_rx",  {rx_byte[3], 6'd0, rx_cnt[3]}, 16'hAB01);
        chk("t6_pre_miso", {15'd0, miso[3]}, 16'h0001);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_miso",  {15'd0, miso[3]},    16'h0000);
        chk("t6_rst_en",    {15'd0, miso_en[3]}, 16'h0000);
        chk("t6_rst_ready", {15'd0, tx_rdy[3]},  16'h0001);
        chk("t6_rst_rx",    {rx_byte[3], 6'd0, rx_cnt[3]}, 16'h0000);
        chk("t6_rst_pulses", {14'd0, undr[3], rx_dv[3]}, 16'h0000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    rxq.delete();
    mtx[0] = 8'hE7;
    frame(3, 1, 8);
    chk("t6_rx_after", pop_rx(), 16'hE701);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
